// File: rtl/fjmem_pkg.sv
// fjmem_pkg: access-sequencer states and requester ids shared by the flash arbiter
package fjmem_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} mid_t;
endpackage

// File: rtl/fjmem_flash_arb.sv
// fjmem_flash_arb: round-robin sharing of a NOR flash bus between the JTAG flasher and the SoC port
module fjmem_flash_arb
  import fjmem_pkg::*;
#(
  parameter int adr_width = 24,
  parameter int rd_wait   = 12,
  parameter int wr_wait   = 12
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 jtag_lock,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [adr_width-1:0] m0_adr,
  input  logic [15:0]          m0_dat_w,
  output logic [15:0]          m0_dat_r,
  output logic                 m0_ack,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [adr_width-1:0] m1_adr,
  input  logic [15:0]          m1_dat_w,
  output logic [15:0]          m1_dat_r,
  output logic                 m1_ack,
  output logic [adr_width-1:0] flash_adr,
  input  logic [15:0]          flash_d_i,
  output logic [15:0]          flash_d_o,
  output logic                 flash_d_oe,
  output logic                 flash_oe_n,
  output logic                 flash_we_n
);
  localparam int cw = $clog2(rd_wait > wr_wait ? rd_wait : wr_wait) + 1;
  state_t state;
  mid_t gnt, last, pick;
  logic we_q, e0, e1, pw;
  logic [cw-1:0] cnt;
  logic [adr_width-1:0] pa;
  logic [15:0] pd;
  // m1 is locked out while the flasher owns the part; ties go to whoever was not served last
  assign e0 = m0_req;
  assign e1 = m1_req & ~jtag_lock;
  assign pick = (e0 && e1) ? (last == M0 ? M1 : M0) : (e1 ? M1 : M0);
  assign pw = pick == M1 ? m1_we : m0_we;
  assign pa = pick == M1 ? m1_adr : m0_adr;
  assign pd = pick == M1 ? m1_dat_w : m0_dat_w;
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      state      <= IDLE;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
      flash_d_oe <= 1'b0;
      flash_adr  <= '0;
      flash_d_o  <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_dat_r   <= '0;
      m1_dat_r   <= '0;
      last       <= M1;
      gnt        <= M0;
      we_q       <= 1'b0;
      cnt        <= '0;
    end else
      case (state)
        IDLE:
          if (e0 || e1) begin
            gnt        <= pick;
            we_q       <= pw;
            flash_adr  <= pa;
            flash_d_o  <= pw ? pd : flash_d_o;
            flash_d_oe <= pw;
            state      <= SETUP;
          end
        SETUP: begin
          flash_oe_n <= we_q;
          flash_we_n <= ~we_q;
          cnt        <= we_q ? cw'(wr_wait - 1) : cw'(rd_wait - 1);
          state      <= STROBE;
        end
        STROBE:
          if (cnt == '0) begin
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            if (!we_q && gnt == M0) m0_dat_r <= flash_d_i;
            if (!we_q && gnt == M1) m1_dat_r <= flash_d_i;
            state      <= HOLD;
          end else
            cnt <= cnt - 1'b1;
        HOLD: begin
          flash_d_oe <= 1'b0;
          m0_ack     <= gnt == M0;
          m1_ack     <= gnt == M1;
          state      <= ACK;
        end
        ACK: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          last   <= gnt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
